des_round_sequencer: RTL

Iterative DES round controller. It accepts one 64-bit half-split block and one 56-bit post-PC-1 key through a valid/ready handshake, and drives a single shared external round unit for 16 rounds. It generates the C/D key-schedule state for each round, in forward order for encryption or reverse order for decryption, and presents the 16-round result through a valid/ready output. It replaces the 16-instance unrolled pipeline where area matters, feeding the same downstream swap/FP stage.

---
 rtl/des_round_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: sequences one shared round unit through 16 rounds
// and walks the C/D key schedule forward (encrypt) or backward (decrypt).
module des_round_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_decrypt,
   input  logic [31:0] data_l,
   input  logic [31:0] data_r,
   input  logic [55:0] key,
   output logic [31:0] rnd_l,
   output logic [31:0] rnd_r,
   output logic [55:0] rnd_cd,
   input  logic [31:0] nxt_l,
   input  logic [31:0] nxt_r,
   output logic [3:0]  rnd_idx,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] data17_l,
   output logic [31:0] data17_r
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Bit n set where the schedule shift s[n] is 1 (n = 1, 2, 9, 16); all others shift by 2.
   localparam logic [31:0] SINGLE_SHIFT = 32'h0001_0206;

   state_t      state_reg, state_next;
   logic [31:0] l_reg, r_reg;
   logic [55:0] cd_reg;
   logic        decrypt_reg;
   logic [3:0]  idx_reg;
   logic        last_round;
   logic [4:0]  shift_pos;
   logic        single_shift;
   logic [55:0] cd_shifted;
   logic [55:0] key_loaded;

   function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic one);
      case ({left, one})
         2'b11:   rot28 = {x[26:0], x[27]};
         2'b10:   rot28 = {x[25:0], x[27:26]};
         2'b01:   rot28 = {x[0], x[27:1]};
         default: rot28 = {x[1:0], x[27:2]};
      endcase
   endfunction

   assign last_round = (idx_reg == 4'd15);

   // Encrypt applies s[k+1] after round k; decrypt undoes s[17-k].
   assign shift_pos    = decrypt_reg ? (5'd16 - {1'b0, idx_reg}) : ({1'b0, idx_reg} + 5'd2);
   assign single_shift = SINGLE_SHIFT[shift_pos];
   assign cd_shifted   = {rot28(cd_reg[55:28], !decrypt_reg, single_shift),
                          rot28(cd_reg[27:0],  !decrypt_reg, single_shift)};

   // Decrypt starts from CD16, which equals the raw key after a full 28-bit walk.
   assign key_loaded = in_decrypt ? key : {rot28(key[55:28], 1'b1, 1'b1), rot28(key[27:0], 1'b1, 1'b1)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid)   state_next = RUN;
         RUN:     if (last_round) state_next = DONE;
         DONE:    if (out_ready)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      busy      = (state_reg == RUN);
      out_valid = (state_reg == DONE);
      rnd_idx   = (state_reg == RUN) ? idx_reg : 4'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_reg       <= '0;
         r_reg       <= '0;
         cd_reg      <= '0;
         decrypt_reg <= 1'b0;
         idx_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  l_reg       <= data_l;
                  r_reg       <= data_r;
                  cd_reg      <= key_loaded;
                  decrypt_reg <= in_decrypt;
                  idx_reg     <= '0;
               end
            end
            RUN: begin
               l_reg   <= nxt_l;
               r_reg   <= nxt_r;
               idx_reg <= idx_reg + 4'd1;
               if (!last_round) begin
                  cd_reg <= cd_shifted;
               end
            end
            default: ;
         endcase
      end
   end

   assign rnd_l    = l_reg;
   assign rnd_r    = r_reg;
   assign rnd_cd   = cd_reg;
   assign data17_l = l_reg;
   assign data17_r = r_reg;

endmodule
